// File: rtl/axi_arbiter_r_rr.sv
// Round-robin read-channel arbiter: grants one master from AR request through
// its final R beat, checks burst length against RLAST, optional stall timeout.
module axi_arbiter_r_rr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TOW            = 16,
  localparam int unsigned IDW           = $clog2(NUM_MASTERS)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_MASTERS-1:0] m_arvalid,
  input  logic [NUM_MASTERS-1:0] m_rready,
  input  logic                   s_arready,
  input  logic [7:0]             s_arlen,
  input  logic                   s_rvalid,
  input  logic                   s_rlast,
  input  logic                   len_err_clr,
  output logic [NUM_MASTERS-1:0] m_rgrnt,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   len_err,
  output logic                   timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDW-1:0]         r_ptr, w_ptr_nxt;
  logic [IDW-1:0]         r_grant_id, w_grant_id_nxt;
  logic [NUM_MASTERS-1:0] r_rgrnt, w_rgrnt_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_len_err, w_len_err_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic [7:0]             r_beat_cnt, w_beat_cnt_nxt;
  logic [TOW-1:0]         r_tcnt, w_tcnt_nxt;

  logic                   w_found;
  logic [IDW-1:0]         w_win;
  logic                   w_beat;
  logic                   w_exp_last;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                               input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    return IDW'(s % NUM_MASTERS);
  endfunction

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && m_arvalid[wrap_add(r_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, i);
      end
    end
  end

  assign w_beat     = s_rvalid && m_rready[r_grant_id];
  assign w_exp_last = (r_beat_cnt == 8'd0);

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_rgrnt_nxt    = r_rgrnt;
    w_busy_nxt     = r_busy;
    w_beat_cnt_nxt = r_beat_cnt;
    w_tcnt_nxt     = r_tcnt;
    w_timeout_nxt  = 1'b0;
    w_len_err_nxt  = r_len_err && !len_err_clr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_id_nxt = w_win;
          w_rgrnt_nxt    = NUM_MASTERS'(1) << w_win;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_arvalid[r_grant_id] && s_arready) begin
          w_beat_cnt_nxt = s_arlen;
          w_tcnt_nxt     = '0;
          w_state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          w_beat_cnt_nxt = w_exp_last ? 8'd0 : r_beat_cnt - 8'd1;
          w_tcnt_nxt     = '0;
          // A new error takes precedence over a simultaneous clear.
          if (s_rlast != w_exp_last) w_len_err_nxt = 1'b1;
          if (s_rlast) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = wrap_add(r_grant_id, 1);
            w_rgrnt_nxt = '0;
            w_busy_nxt  = 1'b0;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (r_tcnt == TOW'(TIMEOUT_CYCLES - 1)) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
            w_ptr_nxt     = wrap_add(r_grant_id, 1);
            w_rgrnt_nxt   = '0;
            w_busy_nxt    = 1'b0;
          end else begin
            w_tcnt_nxt = r_tcnt + TOW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_rgrnt    <= '0;
      r_busy     <= 1'b0;
      r_len_err  <= 1'b0;
      r_timeout  <= 1'b0;
      r_beat_cnt <= 8'd0;
      r_tcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_rgrnt    <= w_rgrnt_nxt;
      r_busy     <= w_busy_nxt;
      r_len_err  <= w_len_err_nxt;
      r_timeout  <= w_timeout_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
    end
  end

  assign m_rgrnt  = r_rgrnt;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign len_err  = r_len_err;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_axi_arbiter_r_rr.sv
// Scoreboard bench for axi_arbiter_r_rr: stimulus queues expected grants,
// a negedge monitor checks each new grant; timing checks are inline.
module tb_axi_arbiter_r_rr;
  localparam int unsigned N = 4;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [N-1:0] m_arvalid = '0;
  logic [N-1:0] m_rready = '1;
  logic         s_arready = 1'b0;
  logic [7:0]   s_arlen = 8'd0;
  logic         s_rvalid = 1'b0;
  logic         s_rlast = 1'b0;
  logic         len_err_clr = 1'b0;
  logic [N-1:0] m_rgrnt;
  logic [1:0]   grant_id;
  logic         busy, len_err, timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  logic [N-1:0] prev_grnt = '0;

  axi_arbiter_r_rr #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(8), .TOW(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .m_arvalid(m_arvalid), .m_rready(m_rready),
    .s_arready(s_arready), .s_arlen(s_arlen), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .len_err_clr(len_err_clr), .m_rgrnt(m_rgrnt),
    .grant_id(grant_id), .busy(busy), .len_err(len_err), .timeout(timeout)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each fresh grant is matched against the next queued expectation.
  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_grnt = '0;
    end else begin
      if (m_rgrnt != '0 && prev_grnt == '0) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 32'(m_rgrnt), 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("grant_onehot", 32'(m_rgrnt), 32'(1) << e);
          chk("grant_id", 32'(grant_id), 32'(e));
        end
      end
      prev_grnt = m_rgrnt;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    chk("rst_grnt", 32'(m_rgrnt), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    m_arvalid = '0; m_rready = '1; s_arready = 1'b0; s_arlen = 8'd0;
    s_rvalid = 1'b0; s_rlast = 1'b0; len_err_clr = 1'b0;
    tick();
    ARESET = 1'b0;
  endtask

  task automatic burst(input logic [N-1:0] req, input int exp_g, input int len,
                       input int last_at, input bit clr_b0);
    exp_q.push_back(exp_g);
    m_arvalid = req;
    tick();
    chk("busy_addr", 32'(busy), 32'd1);
    s_arlen = 8'(len);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      s_rvalid = 1'b1;
      s_rlast = (b == last_at);
      len_err_clr = clr_b0 && (b == 0);
      tick();
      len_err_clr = 1'b0;
      if (b < last_at) chk("grant_held", 32'(m_rgrnt), 32'(1) << exp_g);
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    chk("rel_grnt", 32'(m_rgrnt), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    do_reset();

    // Single requester 2, single-beat burst.
    burst(4'b0100, 2, 0, 0, 1'b0);
    chk("single_len_err", 32'(len_err), 32'd0);
    m_arvalid = '0;

    // All requesting: grants rotate 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 5; k++) burst(4'b1111, k % 4, 3, 3, 1'b0);
    chk("rr_len_err", 32'(len_err), 32'd0);

    // Master 1 held through rready stalls (including a stalled RLAST).
    do_reset();
    burst(4'b1111, 0, 0, 0, 1'b0);
    exp_q.push_back(1);
    m_arvalid = 4'b1111;
    tick();
    s_arlen = 8'd1; s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_rready = 4'b1101; s_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_rlast = (i == 2);
      tick();
      chk("stall_held", 32'(m_rgrnt), 32'h2);
    end
    m_rready = 4'b1111; s_rlast = 1'b0;
    tick();
    chk("beat0_held", 32'(m_rgrnt), 32'h2);
    s_rlast = 1'b1;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    chk("stall_release", 32'(m_rgrnt), 32'd0);
    chk("stall_len_err", 32'(len_err), 32'd0);

    // Early RLAST flags len_err; clear removes it.
    burst(4'b1111, 2, 3, 2, 1'b0);
    chk("early_last_err", 32'(len_err), 32'd1);
    m_arvalid = '0;
    len_err_clr = 1'b1;
    tick();
    len_err_clr = 1'b0;
    chk("err_cleared", 32'(len_err), 32'd0);

    // Missing RLAST with concurrent clear: error wins.
    burst(4'b1111, 3, 0, 1, 1'b1);
    chk("err_wins_clr", 32'(len_err), 32'd1);
    m_arvalid = '0;
    len_err_clr = 1'b1;
    tick();
    len_err_clr = 1'b0;
    chk("err_cleared2", 32'(len_err), 32'd0);

    // Timeout: 8 beat-less DATA cycles, then release and grant to g+1.
    exp_q.push_back(0);
    m_arvalid = 4'b1111;
    tick();
    s_arlen = 8'd3; s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_not_yet", 32'(timeout), 32'd0);
      chk("to_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_busy_off", 32'(busy), 32'd0);
    chk("to_grnt_off", 32'(m_rgrnt), 32'd0);
    exp_q.push_back(1);
    tick();
    chk("to_one_cycle", 32'(timeout), 32'd0);
    chk("to_next_grant", 32'(m_rgrnt), 32'h2);
    s_arlen = 8'd0; s_arready = 1'b1;
    tick();
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    chk("to_after_busy", 32'(busy), 32'd0);

    // Reset mid-DATA, then first grant goes to master 0.
    exp_q.push_back(2);
    m_arvalid = 4'b1111;
    tick();
    s_arlen = 8'd3; s_arready = 1'b1;
    tick();
    s_arready = 1'b0; s_rvalid = 1'b1;
    tick();
    s_rvalid = 1'b0;
    do_reset();
    burst(4'b1111, 0, 0, 0, 1'b0);
    m_arvalid = '0;

    // Lone requester re-granted back-to-back.
    burst(4'b0010, 1, 0, 0, 1'b0);
    burst(4'b0010, 1, 0, 0, 1'b0);
    m_arvalid = '0;

    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_arbiter_r_rr.md
# axi_arbiter_r_rr

Parametrised read-channel arbiter for the AXI interconnect, generalising the two-master read arbiter to NUM_MASTERS masters with fair round-robin priority. It sits between the master-side AR/R ports and the shared read datapath mux. It grants one master at a time and holds the grant from AR request through the final R beat. It checks burst length against RLAST and optionally reclaims the bus from a stalled burst.

## Interface
- NUM_MASTERS, 4: number of masters; legal range 2..16.
- IDW, $clog2(NUM_MASTERS): width of grant_id; derived, not overridden.
- TIMEOUT_CYCLES, 0: idle-data cycles before forced release; 0 disables the timeout.
- TOW, 16: width of the timeout counter; TIMEOUT_CYCLES < 2^TOW.
- ACLK  in  1  clock; all logic rises on posedge.
- ARESET  in  1  reset; asynchronous, active-high.
- m_arvalid  in  NUM_MASTERS  ARVALID of each master.
- m_rready  in  NUM_MASTERS  RREADY of each master.
- s_arready  in  1  ARREADY from the selected slave.
- s_arlen  in  8  ARLEN of the currently granted master, supplied by the datapath mux.
- s_rvalid  in  1  shared RVALID.
- s_rlast  in  1  shared RLAST.
- len_err_clr  in  1  clears len_err.
- m_rgrnt  out  NUM_MASTERS  one-hot grant; all-zero when idle.
- grant_id  out  IDW  index of the granted master.
- busy  out  1  high in ADDR or DATA.
- len_err  out  1  sticky burst-length mismatch flag.
- timeout  out  1  one-cycle pulse on forced release.

## Operation
- Registered state machine with states IDLE, ADDR and DATA; all outputs are registered.
- Round-robin pointer ptr (IDW bits) gives the highest-priority index. The winner is the first asserted m_arvalid scanning ptr, ptr+1, … with wrap modulo NUM_MASTERS.
- IDLE:
  - If any m_arvalid is high, latch winner g into grant_id, set m_rgrnt = 1<<g, go to ADDR.
  - Otherwise stay in IDLE with m_rgrnt = 0.
- ADDR:
  - Grant is held.
  - On m_arvalid[g] && s_arready: load beat_cnt = s_arlen, clear tcnt, go to DATA.
  - If m_arvalid[g] drops before the handshake (an AXI violation), the grant is still held.
- DATA: a beat is s_rvalid && m_rready[g].
  - Each beat decrements beat_cnt and clears tcnt.
  - Expected-last is (beat_cnt == 0). If s_rlast != expected-last on any beat, set len_err.
  - A beat with s_rlast = 1 sends the block to IDLE, sets ptr = (g+1) mod NUM_MASTERS, and clears m_rgrnt and busy next cycle.
  - beat_cnt saturates at 0, so extra beats past ARLEN+1 hold 0 and flag len_err until RLAST arrives.
- Timeout:
  - Active only when TIMEOUT_CYCLES != 0.
  - In DATA, tcnt increments each cycle without a beat.
  - When tcnt reaches TIMEOUT_CYCLES: pulse timeout, go to IDLE, set ptr = g+1.
- len_err clear rules:
  - len_err_clr clears len_err.
  - If a new error and len_err_clr occur in the same cycle, the error wins (len_err stays 1).
- Non-winning requesters wait. The grant never changes mid-transaction, whatever other m_arvalid bits do.

## Timing
- Reset values (applied asynchronously while ARESET = 1): m_rgrnt = 0, grant_id = 0, busy = 0, len_err = 0, timeout = 0, ptr = 0, beat_cnt = 0, tcnt = 0, state = IDLE.
- Reset asserted mid-burst: immediate return to reset values, with no completion or error reporting.
- Grant latency: a request sampled in IDLE on cycle t produces m_rgrnt on cycle t+1.
- AR handshake in cycle t puts the block in DATA at t+1. A beat may arrive at t+1.
- Last beat on cycle t: IDLE at t+1, earliest new grant at t+2. There is no same-cycle re-grant.
- Single-beat burst (s_arlen = 0): one beat with s_rlast = 1 completes cleanly.
- A single requester is re-granted back-to-back every burst, since round-robin skips non-requesters.
- Timeout with TIMEOUT_CYCLES = T: T consecutive beat-less DATA cycles give the timeout pulse on the following cycle, simultaneous with the return to IDLE.

## Test plan
- Reset, then m_arvalid = 4'b0100: m_rgrnt = 4'b0100 and grant_id = 2 one cycle later. After s_arready, then a single beat with s_arlen = 0 and s_rlast = 1: idle next cycle with len_err = 0.
- m_arvalid = 4'b1111 held, 4-beat bursts (s_arlen = 3): grants cycle through masters 0, 1, 2, 3, 0 in that order. Each grant lasts from its request through its RLAST beat, with one idle cycle between bursts.
- Master 1 granted, burst in progress, m_arvalid = 4'b1111: m_rgrnt stays 4'b0010 through beats stalled by m_rready[1] = 0. Release occurs only on the RLAST beat.
- s_arlen = 3 with s_rlast on beat 2: len_err = 1 and the bus is released. With len_err_clr pulsed and no new error, len_err = 0 the next cycle.
- TIMEOUT_CYCLES = 8, AR handshake, then no s_rvalid: the timeout pulse and return to IDLE occur 8 cycles after entering DATA. The next grant goes to master g+1 if it is requesting.
- ARESET asserted mid-DATA: all outputs go to 0 asynchronously, and after release the first grant goes to master 0.
